zoom_addr_gen: RTL and testbench

Parametrised, pipelined frame-buffer address generator for the VGA display path. It sits between the sync/timing generator and the image ROM/RAM. It counts active pixels and lines itself and replaces divide-based zoom with per-axis replication counters, so any integer zoom from 1 to MAX_ZOOM is supported. It also adds pan offsets and frame-synchronous latching of zoom and colour mode, and emits the address together with pipeline-aligned channel enables.

---
 rtl/zoom_pkg.sv | 38 +++
 rtl/zoom_addr_gen_if.sv | 38 +++
 rtl/zoom_axis_cnt.sv | 54 +++++
 rtl/zoom_addr_gen.sv | 167 ++++++++++++++++
 tb/tb_zoom_addr_gen.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/zoom_pkg.sv
// Shared types and defaults for the zoom address generator: colour-mode
// encodings, the channel-enable bundle and its decoder.
package zoom_pkg;

  localparam int DEF_IMG_W    = 128;
  localparam int DEF_IMG_H    = 128;
  localparam int DEF_MAX_ZOOM = 8;

  typedef enum logic [2:0] {
    MODE_NORMAL = 3'd0,
    MODE_R_OFF  = 3'd1,
    MODE_G_OFF  = 3'd2,
    MODE_B_OFF  = 3'd3,
    MODE_GSCALE = 3'd4
  } mode_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
    logic alu;
  } en_t;

  // Encodings 5..7 fall through to the normal colour path.
  function automatic en_t decode_mode(input logic [2:0] m);
    en_t e;
    e = '{r: 1'b1, g: 1'b1, b: 1'b1, alu: 1'b0};
    case (mode_e'(m))
      MODE_R_OFF:  e.r   = 1'b0;
      MODE_G_OFF:  e.g   = 1'b0;
      MODE_B_OFF:  e.b   = 1'b0;
      MODE_GSCALE: e.alu = 1'b1;
      default:     ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/zoom_addr_gen_if.sv
// Bus between the display timing generator (master) and the zoom address
// generator (slave): timing strobes and config in, address and enables out.
interface zoom_addr_gen_if
  import zoom_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ZW     = 4,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
);
  // pix_valid strobes one active pixel per cycle; addr_valid marks the
  // matching address exactly two cycles later. There is no backpressure.
  logic                     frame_start;
  logic                     line_start;
  logic                     pix_valid;
  logic [2:0]               mode;
  logic [ZW-1:0]            zoom;
  logic [$clog2(IMG_W)-1:0] pan_x;
  logic [$clog2(IMG_H)-1:0] pan_y;
  logic [ADDR_W-1:0]        addr;
  logic                     addr_valid;
  logic                     in_image;
  logic                     r_en;
  logic                     g_en;
  logic                     b_en;
  logic                     alu_en;

  modport master (
    output frame_start, line_start, pix_valid, mode, zoom, pan_x, pan_y,
    input  addr, addr_valid, in_image, r_en, g_en, b_en, alu_en
  );

  modport slave (
    input  frame_start, line_start, pix_valid, mode, zoom, pan_x, pan_y,
    output addr, addr_valid, in_image, r_en, g_en, b_en, alu_en
  );

endinterface

// File: rtl/zoom_axis_cnt.sv
// One zoom axis: a replication sub-counter that advances a saturating source
// coordinate every `zoom` steps; clear reloads both from load_val / zero.
module zoom_axis_cnt #(
  parameter int ZW             = 4,
  parameter int CW             = 8,
  parameter int LIMIT          = 128,
  parameter bit POS_AFTER_STEP = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  input  logic [CW-1:0] load_val,
  input  logic [ZW-1:0] zoom,
  output logic [CW-1:0] pos
);

  logic [ZW-1:0] sub_q;
  logic [ZW-1:0] sub_base;
  logic [ZW-1:0] sub_next;
  logic [CW-1:0] src_q;
  logic [CW-1:0] src_base;
  logic [CW-1:0] src_next;
  logic          wrap;

  // >= rather than == so a sub-count left over from a larger zoom still wraps.
  always_comb begin
    sub_base = clear ? '0 : sub_q;
    src_base = clear ? load_val : src_q;
    wrap     = step && (sub_base >= zoom - ZW'(1));
    sub_next = sub_base;
    src_next = src_base;
    if (step) begin
      sub_next = wrap ? '0 : sub_base + ZW'(1);
    end
    if (wrap && (src_base < CW'(LIMIT))) begin
      src_next = src_base + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= '0;
      src_q <= '0;
    end else begin
      sub_q <= sub_next;
      src_q <= src_next;
    end
  end

  // X reports the coordinate before this step; Y reports it after a line advance.
  assign pos = POS_AFTER_STEP ? src_next : src_base;

endmodule

// File: rtl/zoom_addr_gen.sv
// Pipelined zoom/pan frame-buffer address generator (two register stages).
// Optional pan offsets are compiled in with `define ZOOM_ADDR_PAN_EN.
module zoom_addr_gen
  import zoom_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int MAX_ZOOM = DEF_MAX_ZOOM,
  parameter int ZW       = 4,
  parameter int ADDR_W   = $clog2(IMG_W * IMG_H)
) (
  input logic            clk,
  input logic            rst,
  zoom_addr_gen_if.slave bus
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int CXW = $clog2(IMG_W + 1);
  localparam int CYW = $clog2(IMG_H + 1);

  logic [ZW-1:0]  zoom_req;
  logic [ZW-1:0]  zoom_q;
  logic [ZW-1:0]  zoom_eff;
  logic [2:0]     mode_q;
  logic [2:0]     mode_eff;
  logic [CXW-1:0] start_x;
  logic [CYW-1:0] start_y;
  logic           line_active;
  logic [CXW-1:0] px;
  logic [CYW-1:0] py;
  logic           step_y;

  logic           s1_valid;
  logic           s1_in;
  logic [XW-1:0]  s1_x;
  logic [YW-1:0]  s1_y;
  en_t            s1_en;

  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              in_q;
  en_t               en_q;

  always_comb begin
    zoom_req = bus.zoom;
    if (bus.zoom == '0) begin
      zoom_req = ZW'(1);
    end else if (bus.zoom > ZW'(MAX_ZOOM)) begin
      zoom_req = ZW'(MAX_ZOOM);
    end
  end

  // On frame_start the freshly sampled settings already apply to that cycle.
  assign zoom_eff = bus.frame_start ? zoom_req : zoom_q;
  assign mode_eff = bus.frame_start ? bus.mode : mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zoom_q <= ZW'(1);
      mode_q <= '0;
    end else if (bus.frame_start) begin
      zoom_q <= zoom_req;
      mode_q <= bus.mode;
    end
  end

`ifdef ZOOM_ADDR_PAN_EN
  logic [XW-1:0] pan_x_q;
  logic [$clog2(IMG_H)-1:0] pan_y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pan_x_q <= '0;
      pan_y_q <= '0;
    end else if (bus.frame_start) begin
      pan_x_q <= bus.pan_x;
      pan_y_q <= bus.pan_y;
    end
  end

  assign start_x = CXW'(bus.frame_start ? bus.pan_x : pan_x_q);
  assign start_y = CYW'(bus.frame_start ? bus.pan_y : pan_y_q);
`else
  logic unused_pan;
  assign unused_pan = ^{bus.pan_x, bus.pan_y};
  assign start_x    = '0;
  assign start_y    = '0;
`endif

  // Rows only advance after a line that actually displayed pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_active <= 1'b0;
    end else if (bus.pix_valid) begin
      line_active <= 1'b1;
    end else if (bus.line_start || bus.frame_start) begin
      line_active <= 1'b0;
    end
  end

  assign step_y = bus.line_start && line_active && !bus.frame_start;

  zoom_axis_cnt #(
    .ZW(ZW), .CW(CXW), .LIMIT(IMG_W), .POS_AFTER_STEP(1'b0)
  ) u_axis_x (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.line_start || bus.frame_start),
    .step     (bus.pix_valid),
    .load_val (start_x),
    .zoom     (zoom_eff),
    .pos      (px)
  );

  zoom_axis_cnt #(
    .ZW(ZW), .CW(CYW), .LIMIT(IMG_H), .POS_AFTER_STEP(1'b1)
  ) u_axis_y (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.frame_start),
    .step     (step_y),
    .load_val (start_y),
    .zoom     (zoom_eff),
    .pos      (py)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_in    <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_en    <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      s1_in    <= bus.pix_valid && (px < CXW'(IMG_W)) && (py < CYW'(IMG_H));
      s1_x     <= px[XW-1:0];
      s1_y     <= py[YW-1:0];
      s1_en    <= decode_mode(mode_eff);
    end
  end

  // IMG_W is a power of two, so row*IMG_W+col is a plain concatenation.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
      in_q    <= 1'b0;
      en_q    <= '0;
    end else begin
      addr_q  <= s1_in ? ADDR_W'({s1_y, s1_x}) : '0;
      valid_q <= s1_valid;
      in_q    <= s1_in;
      en_q    <= s1_en;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.in_image   = in_q;
  assign bus.r_en       = en_q.r;
  assign bus.g_en       = en_q.g;
  assign bus.b_en       = en_q.b;
  assign bus.alu_en     = en_q.alu;

endmodule

// File: tb/tb_zoom_addr_gen.sv
// Directed bench for zoom_addr_gen: stimulus pushes expected outputs, a
// negedge monitor pops and compares them, including the two-cycle latency.
module tb_zoom_addr_gen;

  localparam int W = 51;

  logic        clk;
  logic        rst;
  logic [31:0] cyc;
  int          checks;
  int          errors;
  logic [W-1:0] exp_q[$];

  int m_zoom;
  int m_mode;
  int m_pan_x;
  int m_pan_y;
  int m_line;

  zoom_addr_gen_if #(.IMG_W(128), .IMG_H(128), .ZW(4)) bus ();

  zoom_addr_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exp_en(input int m);
    case (m)
      1:       return 4'b0110;
      2:       return 4'b1010;
      3:       return 4'b1100;
      4:       return 4'b1111;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic push_pix(input int col);
    int sx;
    int row;
    logic in;
    logic [13:0] a;
    sx  = m_pan_x + col / m_zoom;
    if (sx > 128) sx = 128;
    row = m_pan_y + m_line / m_zoom;
    if (row > 128) row = 128;
    in  = (sx < 128) && (row < 128);
    a   = in ? 14'(row * 128 + sx) : 14'd0;
    exp_q.push_back({cyc, in, exp_en(m_mode), a});
  endtask

  task automatic start_frame(input int z, input int m, input int ppx, input int ppy);
    bus.zoom        = 4'(z);
    bus.mode        = 3'(m);
    bus.pan_x       = 7'(ppx);
    bus.pan_y       = 7'(ppy);
    bus.frame_start = 1'b1;
    bus.line_start  = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
    m_zoom = (z == 0) ? 1 : ((z > 8) ? 8 : z);
    m_mode = m;
`ifdef ZOOM_ADDR_PAN_EN
    m_pan_x = ppx;
    m_pan_y = ppy;
`else
    m_pan_x = 0;
    m_pan_y = 0;
`endif
    m_line = 0;
  endtask

  task automatic run_line(input int n, input bit merge);
    if (!merge) begin
      bus.line_start = 1'b1;
      tick();
      bus.line_start = 1'b0;
    end
    for (int c = 0; c < n; c++) begin
      bus.line_start = merge && (c == 0);
      bus.pix_valid  = 1'b1;
      push_pix(c);
      tick();
    end
    bus.line_start = 1'b0;
    bus.pix_valid  = 1'b0;
    tick();
    tick();
    if (n > 0) m_line++;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_addr"}, 32'(bus.addr), 32'd0);
    chk({name, "_ctl"}, {26'd0, bus.addr_valid, bus.in_image,
                         bus.r_en, bus.g_en, bus.b_en, bus.alu_en}, 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    if (!rst && bus.addr_valid) begin
      act = {cyc - 32'd2, bus.in_image, bus.r_en, bus.g_en, bus.b_en, bus.alu_en, bus.addr};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got addr=%0d in=%0b with empty queue",
                 bus.addr, bus.in_image);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL pixel: got cyc=%0d in=%0b en=%b addr=%0d expected cyc=%0d in=%0b en=%b addr=%0d",
                   act[50:19], act[18], act[17:14], act[13:0],
                   e[50:19], e[18], e[17:14], e[13:0]);
        end
      end
    end
  end

  // directed sequence
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.mode        = 3'd0;
    bus.zoom        = 4'd1;
    bus.pan_x       = 7'd0;
    bus.pan_y       = 7'd0;
    m_zoom = 1; m_mode = 0; m_pan_x = 0; m_pan_y = 0; m_line = 0;
    repeat (3) tick();
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk_zero("post_reset_idle");

    // zoom 1, one wide line, columns past 127 fall outside the image
    start_frame(1, 0, 0, 0);
    run_line(640, 1'b0);

    // zoom 3, a blanking line in the middle must not advance the row
    start_frame(3, 0, 0, 0);
    run_line(20, 1'b0);
    run_line(20, 1'b0);
    run_line(0, 1'b0);
    run_line(20, 1'b0);
    run_line(20, 1'b0);

    // zoom 0 behaves as 1; zoom 12 clamps to 8
    start_frame(0, 1, 0, 0);
    run_line(10, 1'b0);
    start_frame(12, 3, 0, 0);
    run_line(20, 1'b0);

    // pan offsets (ignored when the pan feature is compiled out)
    start_frame(1, 0, 10, 2);
    run_line(130, 1'b0);

    // mid-frame zoom/mode change held off until the next frame_start
    start_frame(1, 2, 0, 0);
    run_line(8, 1'b0);
    bus.zoom = 4'd4;
    bus.mode = 3'd0;
    run_line(8, 1'b0);
    start_frame(4, 2, 0, 0);
    run_line(12, 1'b0);

    // line_start coincident with the first pixel; grayscale and mode 5
    start_frame(2, 4, 0, 0);
    run_line(6, 1'b1);
    run_line(6, 1'b1);
    run_line(6, 1'b1);
    start_frame(1, 5, 0, 0);
    run_line(4, 1'b1);

    // one-cycle reset in the middle of a line
    start_frame(3, 3, 0, 0);
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.pix_valid = 1'b1;
      push_pix(c);
      tick();
    end
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    tick();
    exp_q.delete();
    @(negedge clk);
    chk_zero("mid_line_reset");
    rst = 1'b0;
    m_zoom = 1; m_mode = 0; m_pan_x = 0; m_pan_y = 0; m_line = 0;
    tick();
    run_line(5, 1'b0);

    repeat (4) tick();
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
